// File: rtl/simon_iter_ctrl.sv
// simon_iter_ctrl: iterative Simon 32/64 encryption engine.
// Runs one Feistel round per clock and derives each round key on the fly
// from a four-word sliding key window. Drop-in replacement for the flat
// combinational cipher core: it trades latency for area.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   plaintext/keytext valid
//   in_ready   engine idle and able to accept a block
//   plaintext  [31:16]=x, [15:0]=y
//   keytext    [63:48]=k3, [47:32]=k2, [31:16]=k1, [15:0]=k0
//   out_valid  ciphertext valid (held until consumed)
//   out_ready  consumer accepts ciphertext
//   ciphertext {x,y} after the last round
//   busy       rounds in progress
module simon_iter_ctrl #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] plaintext,
  input  logic [63:0] keytext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ciphertext,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // z0 sequence, leftmost bit is z0[0]; only the first 32 entries are used.
  localparam logic [0:31] Z0      = 32'b11111010001001010110000111001101;
  localparam logic [4:0]  LAST_RC = 5'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] kr_q [4];
  logic [15:0] kr_d [4];
  logic [4:0]  rc_q, rc_d;

  logic [15:0] f_x;
  logic [15:0] t;
  logic [15:0] k_new;

  // Round function and next key word, computed from the current registers.
  always_comb begin
    f_x   = ({x_q[14:0], x_q[15]} & {x_q[7:0], x_q[15:8]}) ^ {x_q[13:0], x_q[15:14]};
    t     = {kr_q[3][2:0], kr_q[3][15:3]} ^ kr_q[1];
    k_new = 16'hFFFC ^ {15'd0, Z0[rc_q]} ^ kr_q[0] ^ t ^ {t[0], t[15:1]};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rc_d    = rc_q;
    for (int unsigned i = 0; i < 4; i++) begin
      kr_d[i] = kr_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = plaintext[31:16];
          y_d     = plaintext[15:0];
          kr_d[0] = keytext[15:0];
          kr_d[1] = keytext[31:16];
          kr_d[2] = keytext[47:32];
          kr_d[3] = keytext[63:48];
          rc_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d     = y_q ^ f_x ^ kr_q[0];
        y_d     = x_q;
        kr_d[0] = kr_q[1];
        kr_d[1] = kr_q[2];
        kr_d[2] = kr_q[3];
        kr_d[3] = k_new;
        rc_d    = rc_q + 5'd1;
        if (rc_q == LAST_RC) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rc_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        kr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rc_q    <= rc_d;
      for (int unsigned i = 0; i < 4; i++) begin
        kr_q[i] <= kr_d[i];
      end
    end
  end

  // All handshake outputs come straight from the state register.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == RUN);
  assign ciphertext = {x_q, y_q};

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// Self-checking bench for simon_iter_ctrl: scoreboard of expected
// ciphertexts pushed at the accept edge and compared at the output handshake.
module tb_simon_iter_ctrl;

  localparam logic [61:0] ZC = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [63:0] KEY1 = 64'h1918111009080100;
  localparam logic [31:0] PT1  = 32'h65656877;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] plaintext, ciphertext;
  logic [63:0] keytext;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [31:0] plaintext1, ciphertext1;
  logic [63:0] keytext1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;

  logic [31:0] exp_q [$];
  int          acc_q [$];
  int          rise_cyc [$];
  logic [31:0] last_ct;
  logic        ov_prev = 1'b0;
  logic        hs_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simon_iter_ctrl #(.ROUNDS(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .keytext(keytext), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
  );

  simon_iter_ctrl #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .plaintext(plaintext1), .keytext(keytext1), .out_valid(out_valid1),
    .out_ready(out_ready1), .ciphertext(ciphertext1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Reference Simon 32/64 with the key schedule expanded up front.
  function automatic logic [31:0] simon_ref(input logic [31:0] pt, input logic [63:0] key,
                                            input int rounds);
    logic [15:0] k [36];
    logic [15:0] x, y, tmp;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 4; i < 36; i++) begin
      tmp  = ror(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ ror(tmp, 1);
      k[i] = ~k[i-4] ^ tmp ^ {15'd0, ZC[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < rounds; r++) begin
      tmp = x;
      x   = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[r];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // Output monitor / scoreboard for the ROUNDS=32 instance.
  always @(negedge clk) begin
    if (!rst) begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      check("in_ready_out_valid_excl", {63'd0, in_ready & out_valid}, 64'd0);
      if (hs_prev) begin
        check("out_valid_one_cycle", {63'd0, out_valid}, 64'd0);
        check("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
      end
      if (out_valid && !ov_prev) begin
        rise_cyc.push_back(cyc);
        if (acc_q.size() == 0) check("out_without_accept", acc_q.size(), 64'd1);
        else check("latency", cyc - acc_q.pop_front(), 64'd32);
      end
      hs_prev = out_valid && out_ready;
      if (hs_prev) begin
        n_out++;
        last_ct = ciphertext;
        if (exp_q.size() == 0) check("ct_without_expect", exp_q.size(), 64'd1);
        else check("ciphertext", {32'd0, ciphertext}, {32'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(simon_ref(plaintext, keytext, 32));
        acc_q.push_back(cyc + 1);
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [31:0] pt, input logic [63:0] key);
    bit ok = 0;
    @(posedge clk); #1;
    plaintext = pt;
    keytext   = key;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", exp_q.size(), 64'd0);
  endtask

  initial begin
    int n0, r0;
    bit ok;
    rst = 1'b0;
    in_valid = 0; out_ready = 1; plaintext = '0; keytext = '0;
    in_valid1 = 0; out_ready1 = 1; plaintext1 = '0; keytext1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ct", {32'd0, ciphertext}, 64'd0);
    check("rst_ct_r1", {32'd0, ciphertext1}, 64'd0);
    rst = 1'b1;

    // Standard vector
    send(PT1, KEY1);
    repeat (5) @(negedge clk);
    check("busy_in_run", {63'd0, busy}, 64'd1);
    check("in_ready_in_run", {63'd0, in_ready}, 64'd0);
    drain();
    check("vec1_const", {32'd0, last_ct}, {32'd0, 32'hC69BE9BB});

    // ROUNDS=1 instance
    @(posedge clk); #1;
    plaintext1 = PT1; keytext1 = KEY1; in_valid1 = 1'b1;
    @(negedge clk);
    check("r1_in_ready", {63'd0, in_ready1}, 64'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    plaintext1 = '1;
    @(negedge clk);
    check("r1_busy", {63'd0, busy1}, 64'd1);
    check("r1_no_out_yet", {63'd0, out_valid1}, 64'd0);
    @(negedge clk);
    check("r1_out_valid", {63'd0, out_valid1}, 64'd1);
    check("r1_ct_model", {32'd0, ciphertext1}, {32'd0, simon_ref(PT1, KEY1, 1)});
    check("r1_ct_const", {32'd0, ciphertext1}, {32'd0, 32'hBCA26565});
    @(negedge clk);
    check("r1_in_ready_after", {63'd0, in_ready1}, 64'd1);
    check("r1_out_valid_drop", {63'd0, out_valid1}, 64'd0);

    // Input while busy is ignored
    n0 = n_out;
    send(PT1, KEY1);
    @(posedge clk); #1;
    plaintext = 32'hFFFFFFFF;
    in_valid  = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    check("busy_ignore_count", n_out - n0, 64'd1);
    check("busy_ignore_ct", {32'd0, last_ct}, {32'd0, 32'hC69BE9BB});

    // Back-pressure
    out_ready = 1'b0;
    send(PT1, KEY1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) check("bp_out_timeout", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_ct_stable", {32'd0, ciphertext}, {32'd0, 32'hC69BE9BB});
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back with in_valid held high
    n0 = n_out;
    r0 = rise_cyc.size();
    @(posedge clk); #1;
    plaintext = PT1; keytext = KEY1; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rise_cyc.size() >= r0 + 2) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    if (!ok) check("b2b_timeout", rise_cyc.size() - r0, 64'd2);
    drain();
    if (rise_cyc.size() >= r0 + 2)
      check("b2b_gap", rise_cyc[r0+1] - rise_cyc[r0], 64'd34);
    check("b2b_count", n_out - n0, 64'd2);

    // Reset mid-RUN
    n0 = n_out;
    send(PT1, KEY1);
    repeat (14) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_output", n_out - n0, 64'd0);
    send(PT1, KEY1);
    drain();
    check("after_rst_ct", {32'd0, last_ct}, {32'd0, 32'hC69BE9BB});
    check("after_rst_count", n_out - n0, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_iter_ctrl.md
# simon_iter_ctrl

Iterative Simon 32/64 encryption engine with a round scheduler and an on-the-fly key schedule. It takes one plaintext/key pair over a valid/ready handshake and runs one round per clock for ROUNDS cycles. The ciphertext is held on a valid/ready output until it is consumed. It sits directly behind the pad ring, in place of the flat combinational cipher core, and trades latency for area.

## Interface

Parameters:
- ROUNDS, 32, number of rounds executed. Legal range 1..32; 32 is standard Simon 32/64.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext/keytext valid.
- in_ready  output  1  block can accept; equals (state==IDLE).
- plaintext  input  32  [31:16]=x, [15:0]=y.
- keytext  input  64  [63:48]=k3, [47:32]=k2, [31:16]=k1, [15:0]=k0.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  32  [31:16]=x, [15:0]=y after the last round.
- busy  output  1  high in RUN.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load x/y from plaintext, load key regs kr[0..3]=k0..k3, clear round counter rc (5 bits), go to RUN.
- RUN, one round per cycle:
  - x ← y ^ f(x) ^ kr[0].
  - y ← x.
  - f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x).
- Key schedule, same cycle as each round:
  - kr[0..2] ← kr[1..3].
  - kr[3] ← 0xFFFC ^ z0[rc] ^ kr[0] ^ t ^ rotr1(t), with t = rotr3(kr[3]) ^ kr[1].
  - z0[rc] enters at bit 0 only.
- z0 is the 62-bit constant 11111010001001010110000111001101111101000100101011000011100110, leftmost bit = z0[0]. Only indices 0..31 are ever used, so it can be stored as 32 bits.
- rc increments every RUN cycle. When rc==ROUNDS-1, the round completes and the FSM goes to DONE.
- DONE:
  - out_valid=1, ciphertext={x,y}.
  - Ciphertext is held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
- in_valid outside IDLE is ignored; no input is latched.
- plaintext/keytext are sampled only at the accept edge. Later changes have no effect.
- All 16-bit arithmetic is bitwise, with rotations modulo 16. There are no carries.

## Timing

- Reset (rst low, asynchronous):
  - state=IDLE, rc=0.
  - x, y, kr all 0.
  - out_valid=0, busy=0, in_ready=1, ciphertext=0.
- Reset mid-RUN or mid-DONE aborts immediately. The pending result is lost; no out_valid pulse follows.
- Latency:
  - Accept at edge E.
  - Rounds execute at edges E+1..E+ROUNDS.
  - out_valid is high from just after edge E+ROUNDS.
  - With ROUNDS=32: 32 cycles from accept to result.
- With out_ready held high, out_valid lasts exactly 1 cycle. in_ready returns the cycle after the output handshake.
- Minimum initiation interval is ROUNDS+2 cycles. There is no overlap between operations.
- in_ready and out_valid are never high together. in_ready is registered-state derived, with no combinational path from in_valid.
- out_ready low in DONE stalls indefinitely. in_ready stays 0 for the whole stall.

## Test plan

1. Standard vector, ROUNDS=32: key 0x1918111009080100, plaintext 0x65656877, out_ready=1 → ciphertext 0xC69BE9BB. out_valid rises exactly 32 cycles after the accept edge and lasts 1 cycle.
2. ROUNDS=1, same inputs → ciphertext 0xBCA26565 one cycle after accept.
3. Back-pressure: vector 1 with out_ready=0 for 10 cycles after out_valid rises → ciphertext stable at 0xC69BE9BB, in_ready=0 throughout. After out_ready=1, in_ready=1 on the next cycle.
4. Input while busy: during RUN, drive in_valid=1 with plaintext 0xFFFFFFFF → ignored; ciphertext is still 0xC69BE9BB.
5. Back-to-back: two vector-1 transactions with in_valid held high and out_ready=1 → two identical results 34 cycles apart.
6. Reset at round 15 of RUN: rst low for 1 cycle → out_valid=0, busy=0, in_ready=1. No result is produced. A fresh vector 1 then yields 0xC69BE9BB.
